hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Parametrised decode-stage hazard tracker for the pipelined MIPS core. It consumes the per-instruction Tuse/Tnew/MD classification produced by the decode control unit and keeps a shadow pipeline of destination registers and remaining Tnew for every stage after D. From that state it generates the D-stage stall and the per-operand D-stage forward selects. It also holds an internal multiply/divide busy counter, so HI/LO instructions stall while the MD unit is occupied.

## Interface
- STAGES, 3, number of tracked stages after D (1 = E … STAGES = last write-back stage); ≥1
- TNEW_W, 2, width of Tnew/Tuse fields
- REG_AW, 5, register address width
- MULT_LAT, 5, busy cycles after a mult/multu issues
- DIV_LAT, 10, busy cycles after a div/divu issues
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- d_valid  in  1  D holds a real instruction
- d_rs, d_rt  in  REG_AW each  source register addresses
- d_rs_tuse, d_rt_tuse  in  TNEW_W each  cycles until operand consumed; all-ones = operand unused
- d_we  in  1  instruction writes the register file
- d_dst  in  REG_AW  destination address
- d_tnew  in  TNEW_W  Tnew on entry to stage 1 (E)
- d_md  in  1  instruction touches HI/LO or the MD unit
- d_md_start  in  1  instruction starts a mult/div
- d_md_div  in  1  when d_md_start: 1 = divide, 0 = multiply
- stall  out  1  freeze PC and the D register; insert a bubble into E
- rs_fwd, rt_fwd  out  $clog2(STAGES+1) each  0 = register file; k = forward from stage k
- md_busy  out  1  MD counter non-zero

## Operation
- State: STAGES entries {valid, we, dst, tnew}, plus an MD counter sized for max(MULT_LAT, DIV_LAT).
- Issue = d_valid & ~stall.
- Shift, every cycle regardless of stall:
  - entry k+1 ← entry k, with tnew decremented and saturating at 0;
  - entry 1 ← {issue, d_we, d_dst, d_tnew}, or a bubble (valid = 0) when not issuing;
  - entry STAGES is discarded.
- Match for an operand (per rs/rt): entry valid & we & dst == operand & operand ≠ 0. Only the youngest (lowest k) matching entry counts.
- Operand hazard: a match exists, that entry's tnew > the operand's tuse, and tuse is not all-ones.
- Forward select: k of the youngest match when its tnew == 0; otherwise 0. Reported even when stall = 1.
- MD counter:
  - on an issued d_md_start, load MULT_LAT or DIV_LAT (per d_md_div);
  - otherwise decrement while non-zero.
- MD hazard: d_md & (counter ≠ 0).
- stall = d_valid & (rs hazard | rt hazard | MD hazard).
- d_valid = 0 → stall = 0 and no issue; a bubble enters.
- Register 0 never creates a hazard or a forward.

## Timing
- stall, rs_fwd, rt_fwd: combinational from D inputs and current state; no added latency.
- md_busy: registered, equal to (counter ≠ 0).
- All state updates on the rising clk edge.
- reset low → immediately, asynchronously: all entries invalid, counter = 0. Outputs then read stall = 0, rs_fwd = rt_fwd = 0, md_busy = 0.
- Reset mid-stall or mid-MD-operation discards all pending state; the first cycle after release behaves as an empty pipeline.
- Stall length for a single producer = tnew − tuse cycles, because tnew drops by 1 per shift while D is frozen.
- A multiply blocks a following HI/LO instruction for exactly MULT_LAT cycles; a divide for DIV_LAT. Counter load and decrement never coincide, since an issuing MD instruction implies counter == 0.
- Simultaneous rs and rt hazards: one stall signal, held until both clear.

## Test plan
- lw $1 (d_tnew = 2) issues at cycle 0; addu with rs = $1, tuse = 1 in D at cycle 1 → stall = 1 at cycle 1, stall = 0 at cycle 2, rs_fwd = 0 at cycle 2.
- addu $2 (d_tnew = 1) at cycle 0; beq with rs = $2, tuse = 0 at cycle 1 → stall at cycle 1; at cycle 2 stall = 0 and rs_fwd = 2.
- Producer writing $0 (d_tnew = 2), then a consumer of $0 with tuse = 0 → stall = 0, rs_fwd = 0.
- Two producers of $3: older ori at stage 2 with tnew 0, younger lw at stage 1 with tnew 2; consumer tuse = 2 → stall = 0 and rs_fwd = 0 (youngest match wins, its tnew ≠ 0).
- mult issues at cycle 0 (MULT_LAT = 5); mflo in D from cycle 1 → stall in cycles 1–5, issue at cycle 6, md_busy high cycles 1–5. With div (DIV_LAT = 10) the stall covers cycles 1–10.
- reset pulsed low during the mult stall at cycle 3 → stall and md_busy go to 0 immediately; after release, mflo issues with no stall.

Source files
------------

// File: rtl/hazard_tracker_if.sv
// D-stage hazard tracker bus: decode classification in, stall/forward/busy out.
interface hazard_tracker_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TNEW_W = 2,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned FWD_W = $clog2(STAGES + 1);

  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [TNEW_W-1:0] d_rt_tuse;
  logic              d_we;
  logic [REG_AW-1:0] d_dst;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md;
  logic              d_md_start;
  logic              d_md_div;
  logic              stall;
  logic [FWD_W-1:0]  rs_fwd;
  logic [FWD_W-1:0]  rt_fwd;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_dst, d_tnew,
           d_md, d_md_start, d_md_div,
    input  stall, rs_fwd, rt_fwd, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_dst, d_tnew,
           d_md, d_md_start, d_md_div,
    output stall, rs_fwd, rt_fwd, md_busy
  );
endinterface

// File: rtl/hazard_tracker.sv
// Decode-stage hazard tracker: shadow pipeline of destinations/Tnew for the
// stages after D, producing the D stall, per-operand forward selects and an
// MD-unit busy counter that holds back HI/LO instructions.
module hazard_tracker #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic              clk,
  input logic              reset,
  hazard_tracker_if.slave  bus
);
  localparam int unsigned FWD_W   = $clog2(STAGES + 1);
  localparam int unsigned MD_MAX  = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CNT_W   = $clog2(MD_MAX + 1);

  logic              e_valid [1:STAGES];
  logic              e_we    [1:STAGES];
  logic [REG_AW-1:0] e_dst   [1:STAGES];
  logic [TNEW_W-1:0] e_tnew  [1:STAGES];
  logic [CNT_W-1:0]  md_cnt;

  logic              rs_hit, rt_hit;
  logic [FWD_W-1:0]  rs_k, rt_k;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;
  logic              rs_haz, rt_haz, md_haz;
  logic              stall;
  logic              issue;

  // Youngest-match search: scan oldest to youngest so the lowest k wins.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_k    = '0;
    rt_k    = '0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (e_valid[STAGES-i] && e_we[STAGES-i] &&
          e_dst[STAGES-i] == bus.d_rs && bus.d_rs != '0) begin
        rs_hit  = 1'b1;
        rs_k    = FWD_W'(STAGES - i);
        rs_tnew = e_tnew[STAGES-i];
      end
      if (e_valid[STAGES-i] && e_we[STAGES-i] &&
          e_dst[STAGES-i] == bus.d_rt && bus.d_rt != '0) begin
        rt_hit  = 1'b1;
        rt_k    = FWD_W'(STAGES - i);
        rt_tnew = e_tnew[STAGES-i];
      end
    end
  end

  // Stall and forward-select generation from the youngest matches.
  always_comb begin
    rs_haz = rs_hit && (rs_tnew > bus.d_rs_tuse) && (bus.d_rs_tuse != '1);
    rt_haz = rt_hit && (rt_tnew > bus.d_rt_tuse) && (bus.d_rt_tuse != '1);
    md_haz = bus.d_md && (md_cnt != '0);
    stall  = bus.d_valid && (rs_haz || rt_haz || md_haz);
    issue  = bus.d_valid && !stall;
  end

  assign bus.stall   = stall;
  assign bus.rs_fwd  = (rs_hit && rs_tnew == '0) ? rs_k : '0;
  assign bus.rt_fwd  = (rt_hit && rt_tnew == '0) ? rt_k : '0;
  assign bus.md_busy = (md_cnt != '0);

  // Shadow pipeline shift: advances every cycle, bubble when D does not issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 1; k <= STAGES; k++) begin
        e_valid[k] <= 1'b0;
        e_we[k]    <= 1'b0;
        e_dst[k]   <= '0;
        e_tnew[k]  <= '0;
      end
    end else begin
      e_valid[1] <= issue;
      e_we[1]    <= bus.d_we;
      e_dst[1]   <= bus.d_dst;
      e_tnew[1]  <= bus.d_tnew;
      for (int unsigned k = 2; k <= STAGES; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_we[k]    <= e_we[k-1];
        e_dst[k]   <= e_dst[k-1];
        e_tnew[k]  <= (e_tnew[k-1] == '0) ? '0 : e_tnew[k-1] - 1'b1;
      end
    end
  end

  // MD busy counter: load on an issued mult/div, otherwise count down to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (issue && bus.d_md_start) begin
      md_cnt <= bus.d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker with hand-computed stall/forward values.
module tb_hazard_tracker;
  localparam int unsigned STAGES   = 3;
  localparam int unsigned TNEW_W   = 2;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic clk;
  logic reset;
  int unsigned checks = 0;
  int unsigned errors = 0;

  hazard_tracker_if #(.STAGES(STAGES), .TNEW_W(TNEW_W), .REG_AW(REG_AW)) bus ();

  hazard_tracker #(
    .STAGES(STAGES), .TNEW_W(TNEW_W), .REG_AW(REG_AW),
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one D-stage instruction; tuse 3 marks an unused operand.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rs_tu,
                       input logic [4:0] rt, input logic [1:0] rt_tu,
                       input logic we, input logic [4:0] dst, input logic [1:0] tnew,
                       input logic md, input logic ms, input logic mdiv);
    bus.d_valid    = v;
    bus.d_rs       = rs;
    bus.d_rs_tuse  = rs_tu;
    bus.d_rt       = rt;
    bus.d_rt_tuse  = rt_tu;
    bus.d_we       = we;
    bus.d_dst      = dst;
    bus.d_tnew     = tnew;
    bus.d_md       = md;
    bus.d_md_start = ms;
    bus.d_md_div   = mdiv;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      idle();
      cyc();
    end
  endtask

  // mflo: reads HI/LO, writes $7 with tnew 1
  task automatic mflo();
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    mflo();
    check("rst_stall", bus.stall, 0);
    check("rst_rs_fwd", bus.rs_fwd, 0);
    check("rst_rt_fwd", bus.rt_fwd, 0);
    check("rst_md_busy", bus.md_busy, 0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // lw $1 (tnew 2), then addu using $1 with tuse 1
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    check("lw_issue_stall", bus.stall, 0);
    cyc();
    drive(1'b1, 5'd1, 2'd1, 5'd5, 2'd3, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    check("lw_use_stall_c1", bus.stall, 1);
    check("lw_use_fwd_c1", bus.rs_fwd, 0);
    cyc();
    drive(1'b1, 5'd1, 2'd1, 5'd5, 2'd3, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    check("lw_use_stall_c2", bus.stall, 0);
    check("lw_use_fwd_c2", bus.rs_fwd, 0);
    cyc();
    flush();

    // addu $2 (tnew 1), then beq rs=$2 tuse 0, rt=$0 tuse 0
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd2, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("beq_stall_c1", bus.stall, 1);
    cyc();
    drive(1'b1, 5'd2, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("beq_stall_c2", bus.stall, 0);
    check("beq_rs_fwd_c2", bus.rs_fwd, 2);
    check("beq_rt_fwd_c2", bus.rt_fwd, 0);
    cyc();
    flush();

    // producer of $0 never hazards or forwards
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("r0_stall", bus.stall, 0);
    check("r0_rs_fwd", bus.rs_fwd, 0);
    check("r0_rt_fwd", bus.rt_fwd, 0);
    cyc();
    flush();

    // ori $3 (tnew 1), lw $3 (tnew 2), consumer rs=$3 tuse 2
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0);
    check("two_prod_lw_stall", bus.stall, 0);
    cyc();
    drive(1'b1, 5'd3, 2'd2, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("youngest_stall", bus.stall, 0);
    check("youngest_rs_fwd", bus.rs_fwd, 0);
    cyc();
    flush();

    // lw $5, lw $6, consumer rs=$5 rt=$6 both tuse 0: one stall until both clear
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd6, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd5, 2'd0, 5'd6, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("dual_stall_c2", bus.stall, 1);
    cyc();
    drive(1'b1, 5'd5, 2'd0, 5'd6, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("dual_stall_c3", bus.stall, 1);
    check("dual_rs_fwd_c3", bus.rs_fwd, 3);
    check("dual_rt_fwd_c3", bus.rt_fwd, 0);
    cyc();
    drive(1'b1, 5'd5, 2'd0, 5'd6, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("dual_stall_c4", bus.stall, 0);
    check("dual_rs_fwd_c4", bus.rs_fwd, 0);
    check("dual_rt_fwd_c4", bus.rt_fwd, 3);
    cyc();
    flush();

    // mult then mflo: stall cycles 1..MULT_LAT
    drive(1'b1, 5'd8, 2'd3, 5'd9, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    check("mult_issue_stall", bus.stall, 0);
    check("mult_issue_busy", bus.md_busy, 0);
    cyc();
    for (int c = 1; c <= int'(MULT_LAT); c++) begin
      mflo();
      check($sformatf("mult_stall_c%0d", c), bus.stall, 1);
      check($sformatf("mult_busy_c%0d", c), bus.md_busy, 1);
      cyc();
    end
    mflo();
    check("mult_release_stall", bus.stall, 0);
    check("mult_release_busy", bus.md_busy, 0);
    cyc();
    flush();

    // div then mflo: stall cycles 1..DIV_LAT
    drive(1'b1, 5'd8, 2'd3, 5'd9, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    cyc();
    for (int c = 1; c <= int'(DIV_LAT); c++) begin
      mflo();
      check($sformatf("div_stall_c%0d", c), bus.stall, 1);
      cyc();
    end
    mflo();
    check("div_release_stall", bus.stall, 0);
    check("div_release_busy", bus.md_busy, 0);
    cyc();
    flush();

    // async reset mid mult stall
    drive(1'b1, 5'd8, 2'd3, 5'd9, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    mflo();
    cyc();
    mflo();
    cyc();
    mflo();
    check("prerst_stall_c3", bus.stall, 1);
    reset = 1'b0;
    #1;
    check("async_rst_stall", bus.stall, 0);
    check("async_rst_busy", bus.md_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_stall", bus.stall, 0);
    cyc();
    mflo();
    check("post_rst_stall_next", bus.stall, 0);
    check("post_rst_busy_next", bus.md_busy, 0);
    cyc();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
